tp_cross_scheduler: RTL and testbench

- Shares one tracklet processor between NSRC per-sector input FIFOs.
- Each FIFO holds one tracklet-count word per bunch crossing.
- Picks a ready source round-robin, waits for the processor to go idle, pops the count word, loads the processor's tracklet counters and starts processing.
- Tracks completion by counting per-tracklet done pulses, then releases the processor for the next source.

---
 rtl/tp_cross_scheduler.sv | 123 ++++++++++++
 tb/tb_tp_cross_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_cross_scheduler.sv
// tp_cross_scheduler: round-robin share of one tracklet processor between NSRC sector FIFOs.
// Optional watchdog abort of a stalled crossing is built when TP_SCHED_WATCHDOG_EN is defined.
module tp_cross_scheduler #(
    parameter int NSRC        = 4,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NSRC-1:0]       src_rdy,
    input  logic [NSRC*CNT_W-1:0] src_cnt,
    output logic [NSRC-1:0]       src_rd_en,
    input  logic                  proc_bsy,
    input  logic                  trk_done,
    output logic                  cntr_ld_en,
    output logic [CNT_W-1:0]      cntr_val,
    output logic                  start_proc,
    output logic [SEL_W-1:0]      src_sel,
    output logic [CNT_W-1:0]      trk_left,
    output logic                  cross_done,
    output logic                  timeout
);
    localparam int NPAD = 2 ** SEL_W;

    typedef enum logic [2:0] {
        S_IDLE, S_TST_BSY, S_RD_FIFO, S_DLY1, S_LD_CNTR, S_RUN, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [SEL_W-1:0] r_sel, r_last, w_grant;
    logic [CNT_W-1:0] r_val, r_left, w_cnt;
    logic [NPAD-1:0]  w_rdy;
    logic             w_to;

    if (NPAD < NSRC || NSRC < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("tp_cross_scheduler: SEL_W too narrow for NSRC, or TIMEOUT_CYC < 2");
    end

    assign w_rdy = NPAD'(src_rdy);

    // pick the first ready source above the last grant, wrapping; the smallest offset wins
    always_comb begin
        int j;
        j       = 0;
        w_grant = '0;
        for (int k = NSRC; k >= 1; k--) begin
            j = int'(r_last) + k;
            if (j >= NSRC) j = j - NSRC;
            if (w_rdy[SEL_W'(j)]) w_grant = SEL_W'(j);
        end
    end

    // count word of the granted source
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NSRC; i++)
            if (r_sel == SEL_W'(i)) w_cnt = src_cnt[i*CNT_W +: CNT_W];
    end

`ifdef TP_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] r_wd;

    // cycles since RUN entry or since the last consumed tracklet
    always_ff @(posedge clk or posedge res) begin
        if (res) r_wd <= '0;
        else if (r_state == S_LD_CNTR || trk_done) r_wd <= '0;
        else if (r_state == S_RUN) r_wd <= r_wd + 1'b1;
    end

    assign w_to = (r_state == S_RUN) && !trk_done && (r_wd == WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_to = 1'b0;
`endif

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = |src_rdy ? S_TST_BSY : S_IDLE;
            S_TST_BSY: w_next = !w_rdy[r_sel] ? S_IDLE : (!proc_bsy ? S_RD_FIFO : S_TST_BSY);
            S_RD_FIFO: w_next = S_DLY1;
            S_DLY1:    w_next = S_LD_CNTR;
            S_LD_CNTR: w_next = (r_left == '0) ? S_DONE : S_RUN;
            S_RUN:     w_next = (w_to || (trk_done && r_left == CNT_W'(1))) ? S_DONE : S_RUN;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // state, grant, pointer and tracklet bookkeeping; the count word is captured on entry to LD_CNTR
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(NSRC - 1);
            r_val   <= '0;
            r_left  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && |src_rdy) r_sel <= w_grant;
            if (r_state == S_DLY1) begin
                r_val  <= w_cnt;
                r_left <= w_cnt;
            end else if (w_to) begin
                r_left <= '0;
            end else if (r_state == S_RUN && trk_done) begin
                r_left <= r_left - 1'b1;
            end
            if (r_state == S_DONE) r_last <= r_sel;
        end
    end

    assign src_rd_en  = (r_state == S_RD_FIFO) ? (NSRC'(1) << r_sel) : '0;
    assign cntr_ld_en = (r_state == S_LD_CNTR);
    assign start_proc = (r_state == S_LD_CNTR);
    assign cross_done = (r_state == S_DONE);
    assign cntr_val   = r_val;
    assign trk_left   = r_left;
    assign src_sel    = r_sel;
    assign timeout    = w_to;
endmodule

// File: tb/tb_tp_cross_scheduler.sv
// tb_tp_cross_scheduler: randomized self-checking bench for tp_cross_scheduler against a transaction-level model.
module tb_tp_cross_scheduler;
    localparam int NSRC = 4;
    localparam int CNT_W = 8;
    localparam int SEL_W = 2;
    localparam int TOUT = 16;

    logic             clk = 0;
    logic             res = 1;
    logic [NSRC-1:0]  src_rdy = '0;
    logic [31:0]      src_cnt = '0;
    logic [NSRC-1:0]  src_rd_en;
    logic             proc_bsy = 0;
    logic             trk_done = 0;
    logic             cntr_ld_en;
    logic [CNT_W-1:0] cntr_val;
    logic             start_proc;
    logic [SEL_W-1:0] src_sel;
    logic [CNT_W-1:0] trk_left;
    logic             cross_done;
    logic             timeout;

    int errors = 0;
    int checks = 0;
    int model_last = NSRC - 1;
    int cur_exp = 0;

    tp_cross_scheduler #(.NSRC(NSRC), .CNT_W(CNT_W), .SEL_W(SEL_W), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .res(res), .src_rdy(src_rdy), .src_cnt(src_cnt), .src_rd_en(src_rd_en),
        .proc_bsy(proc_bsy), .trk_done(trk_done), .cntr_ld_en(cntr_ld_en), .cntr_val(cntr_val),
        .start_proc(start_proc), .src_sel(src_sel), .trk_left(trk_left), .cross_done(cross_done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench time limit expired");
    end

    function automatic int rr_pick(int last, logic [NSRC-1:0] m);
        for (int k = 1; k <= NSRC; k++) begin
            int j = (last + k) % NSRC;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One crossing from IDLE; bsy_n cycles of proc_bsy while the grant waits.
    task automatic do_crossing(input logic [NSRC-1:0] mask, input logic [31:0] cnts, input int bsy_n,
                               input bit stop_in_run, output int got);
        int exp;
        int cnt;
        logic [NSRC-1:0] oh;
        exp = rr_pick(model_last, mask);
        cur_exp = exp;
        cnt = int'(cnts[exp*CNT_W +: CNT_W]);
        oh = NSRC'(1) << exp;
        src_rdy = mask;
        src_cnt = cnts;
        proc_bsy = (bsy_n > 0);
        step();
        got = int'(src_sel);
        checks++;
        if (int'(src_sel) !== exp) begin errors++; $display("FAIL grant: src_sel=%0d expected %0d", src_sel, exp); end
        for (int i = 0; i <= bsy_n; i++) begin
            if (i == bsy_n) proc_bsy = 0;
            checks++;
            if (src_rd_en !== '0) begin errors++; $display("FAIL rd_while_wait: src_rd_en=%b expected 0000", src_rd_en); end
            step();
        end
        checks++;
        if (src_rd_en !== oh) begin errors++; $display("FAIL rd_strobe: src_rd_en=%b expected %b", src_rd_en, oh); end
        step();
        checks++;
        if (src_rd_en !== '0 || start_proc !== 1'b0) begin errors++; $display("FAIL dly1: rd=%b start=%b expected 0000/0", src_rd_en, start_proc); end
        step();
        checks++;
        if (start_proc !== 1'b1 || cntr_ld_en !== 1'b1) begin errors++; $display("FAIL start: start_proc=%b cntr_ld_en=%b expected 1/1", start_proc, cntr_ld_en); end
        checks++;
        if (int'(cntr_val) !== cnt || int'(trk_left) !== cnt) begin errors++; $display("FAIL load: cntr_val=%0d trk_left=%0d expected %0d", cntr_val, trk_left, cnt); end
        if (cnt == 0) begin
            step();
            src_rdy = '0;
            checks++;
            if (cross_done !== 1'b1 || start_proc !== 1'b0) begin errors++; $display("FAIL zero_done: cross_done=%b start=%b expected 1/0", cross_done, start_proc); end
            model_last = exp;
            step();
            checks++;
            if (cross_done !== 1'b0) begin errors++; $display("FAIL done_pulse: cross_done=%b expected 0", cross_done); end
            return;
        end
        step();
        if (stop_in_run) begin
            src_rdy = '0;
            return;
        end
        for (int k = cnt; k >= 1; k--) begin
            repeat ($urandom_range(0, 2)) begin
                checks++;
                if (int'(trk_left) !== k || cross_done !== 1'b0) begin errors++; $display("FAIL run_hold: trk_left=%0d cross_done=%b expected %0d/0", trk_left, cross_done, k); end
                step();
            end
            trk_done = 1;
            step();
            trk_done = 0;
            if (k > 1) begin
                checks++;
                if (int'(trk_left) !== k - 1) begin errors++; $display("FAIL decrement: trk_left=%0d expected %0d", trk_left, k - 1); end
            end
        end
        src_rdy = '0;
        checks++;
        if (cross_done !== 1'b1 || trk_left !== '0) begin errors++; $display("FAIL cross_done: cross_done=%b trk_left=%0d expected 1/0", cross_done, trk_left); end
        model_last = exp;
        step();
        checks++;
        if (cross_done !== 1'b0) begin errors++; $display("FAIL done_pulse: cross_done=%b expected 0", cross_done); end
    endtask

    task automatic test_reset();
        res = 1;
        step();
        step();
        checks++;
        if ({src_rd_en, cntr_ld_en, cntr_val, start_proc, src_sel, trk_left, cross_done, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b ld=%b val=%0d st=%b sel=%0d left=%0d cd=%b to=%b expected all 0",
                     src_rd_en, cntr_ld_en, cntr_val, start_proc, src_sel, trk_left, cross_done, timeout);
        end
        res = 0;
        model_last = NSRC - 1;
        step();
    endtask

    task automatic test_single();
        int got;
        do_crossing(4'b0001, 32'h0000_0003, 0, 0, got);
    endtask

    task automatic test_round_robin();
        int got;
        int order [5] = '{0, 1, 2, 3, 0};
        test_reset();
        for (int n = 0; n < 5; n++) begin
            do_crossing(4'b1111, 32'h0101_0101, 0, 0, got);
            checks++;
            if (got !== order[n]) begin errors++; $display("FAIL rr_order: grant %0d was %0d expected %0d", n, got, order[n]); end
        end
    endtask

    task automatic test_busy_hold();
        int got;
        do_crossing(4'b0100, 32'h0002_0000, 10, 0, got);
    endtask

    task automatic test_withdraw(input logic [NSRC-1:0] mask);
        int exp;
        exp = rr_pick(model_last, mask);
        src_rdy = mask;
        proc_bsy = 1;
        step();
        checks++;
        if (int'(src_sel) !== exp) begin errors++; $display("FAIL wd_grant: src_sel=%0d expected %0d", src_sel, exp); end
        src_rdy = '0;
        repeat (3) begin
            step();
            checks++;
            if (src_rd_en !== '0 || start_proc !== 1'b0) begin errors++; $display("FAIL withdraw: rd=%b start=%b expected 0000/0", src_rd_en, start_proc); end
        end
        proc_bsy = 0;
    endtask

    task automatic test_zero_withdraw();
        int got;
        do_crossing(4'b1001, 32'h0500_0000, 0, 0, got);
        test_withdraw(4'b0110);
        do_crossing(4'b0110, 32'h0004_0400, 1, 0, got);
    endtask

    task automatic test_reset_mid_run();
        int got;
        do_crossing(4'b1000, 32'h0500_0000, 0, 1, got);
        checks++;
        if (trk_left !== 8'd5) begin errors++; $display("FAIL pre_reset: trk_left=%0d expected 5", trk_left); end
        #3 res = 1;
        #1;
        checks++;
        if ({src_rd_en, cntr_ld_en, cntr_val, start_proc, src_sel, trk_left, cross_done, timeout} !== '0) begin
            errors++;
            $display("FAIL async_reset: left=%0d val=%0d sel=%0d expected all 0", trk_left, cntr_val, src_sel);
        end
        step();
        checks++;
        if (src_rd_en !== '0 || cross_done !== 1'b0) begin errors++; $display("FAIL reset_hold: rd=%b cd=%b expected 0000/0", src_rd_en, cross_done); end
        res = 0;
        model_last = NSRC - 1;
        step();
        do_crossing(4'b1111, 32'h0203_0401, 0, 0, got);
        checks++;
        if (got !== 0) begin errors++; $display("FAIL post_reset_grant: src_sel=%0d expected 0", got); end
    endtask

    task automatic test_watchdog();
        int got;
        do_crossing(4'b0010, 32'h0000_0200, 0, 1, got);
`ifdef TP_SCHED_WATCHDOG_EN
        for (int i = 0; i < TOUT - 1; i++) begin
            checks++;
            if (timeout !== 1'b0 || cross_done !== 1'b0) begin errors++; $display("FAIL wd_early: cycle %0d timeout=%b cd=%b expected 0/0", i, timeout, cross_done); end
            step();
        end
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL wd_fire: timeout=%b expected 1", timeout); end
        step();
        checks++;
        if (cross_done !== 1'b1 || timeout !== 1'b0 || trk_left !== '0) begin
            errors++;
            $display("FAIL wd_done: cd=%b timeout=%b trk_left=%0d expected 1/0/0", cross_done, timeout, trk_left);
        end
        model_last = cur_exp;
        step();
`else
        for (int i = 0; i < 3 * TOUT; i++) begin
            checks++;
            if (timeout !== 1'b0 || cross_done !== 1'b0 || trk_left !== 8'd2) begin
                errors++;
                $display("FAIL no_wd: cycle %0d timeout=%b cd=%b trk_left=%0d expected 0/0/2", i, timeout, cross_done, trk_left);
            end
            step();
        end
        trk_done = 1;
        step();
        trk_done = 0;
        checks++;
        if (trk_left !== 8'd1) begin errors++; $display("FAIL no_wd_dec: trk_left=%0d expected 1", trk_left); end
        trk_done = 1;
        step();
        trk_done = 0;
        checks++;
        if (cross_done !== 1'b1) begin errors++; $display("FAIL no_wd_done: cross_done=%b expected 1", cross_done); end
        model_last = cur_exp;
        step();
`endif
    endtask

    task automatic test_random();
        int got;
        logic [NSRC-1:0] m;
        for (int n = 0; n < 40; n++) begin
            m = NSRC'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0) test_withdraw(m);
            else do_crossing(m, $urandom & 32'h0707_0707, $urandom_range(0, 3), 0, got);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_hold();
        test_zero_withdraw();
        test_reset_mid_run();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
